// File: rtl/seg7_frame_decoder_pkg.sv
// Shared glyph table for the 7-segment encoder and the frame decoder.
// Segment order is {a,b,c,d,e,f,g}, active-low (0 = segment lit).
package seg7_pkg;

    localparam int DEFAULT_NUM_DIGITS    = 8;
    localparam int DEFAULT_STABLE_CYCLES = 4;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Forward mapping used by the encoder side of the datapath.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = SEG_A;
            4'hB: pattern = SEG_B;
            4'hC: pattern = SEG_C;
            4'hD: pattern = SEG_D;
            4'hE: pattern = SEG_E;
            default: pattern = SEG_F;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_frame_decoder_if.sv
// Display bus seen by the frame decoder: anode/segment lines and error clear
// going in, reconstructed digits and status coming out.
interface seg7_frame_decoder_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
);

    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    err_clr;
    logic [4*NUM_DIGITS-1:0] hex_value;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    frame_valid;
    logic                    pattern_err;
    logic [2:0]              err_digit;

    // Display driver / stimulus side.
    modport master (
        output an, seg, err_clr,
        input  hex_value, digit_valid, frame_valid, pattern_err, err_digit
    );

    // Decoder side.
    modport slave (
        input  an, seg, err_clr,
        output hex_value, digit_valid, frame_valid, pattern_err, err_digit
    );

endinterface

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the glyph table: segment pattern to nibble,
// flagging blank and legal patterns.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       legal,
    output logic       blank
);

    // Table lookup; anything outside the 16 glyphs and blank is illegal.
    always_comb begin
        hex   = 4'h0;
        legal = 1'b1;
        blank = 1'b0;
        case (seg)
            SEG_0:     hex = 4'h0;
            SEG_1:     hex = 4'h1;
            SEG_2:     hex = 4'h2;
            SEG_3:     hex = 4'h3;
            SEG_4:     hex = 4'h4;
            SEG_5:     hex = 4'h5;
            SEG_6:     hex = 4'h6;
            SEG_7:     hex = 4'h7;
            SEG_8:     hex = 4'h8;
            SEG_9:     hex = 4'h9;
            SEG_A:     hex = 4'hA;
            SEG_B:     hex = 4'hB;
            SEG_C:     hex = 4'hC;
            SEG_D:     hex = 4'hD;
            SEG_E:     hex = 4'hE;
            SEG_F:     hex = 4'hF;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Watches a multiplexed active-low 7-segment display and rebuilds the hex
// value it shows. A digit is captured once per stable dwell on a single
// anode; blank digits, illegal patterns and completed frames are reported.
module seg7_frame_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = DEFAULT_NUM_DIGITS,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seg7_frame_decoder_if.slave  bus
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    logic [3:0]              low_count;
    logic                    one_hot;
    logic [2:0]              sel_idx;
    logic [NUM_DIGITS-1:0]   sel_mask;

    logic [3:0]              dec_hex;
    logic                    dec_legal;
    logic                    dec_blank;

    logic                    capture;
    logic                    illegal;
    logic [NUM_DIGITS-1:0]   seen_next;

    logic [NUM_DIGITS+6:0]   prev_q,    prev_d;
    logic [7:0]              cnt_q,     cnt_d;
    logic                    done_q,    done_d;
    logic [4*NUM_DIGITS-1:0] hex_q,     hex_d;
    logic [NUM_DIGITS-1:0]   valid_q,   valid_d;
    logic [NUM_DIGITS-1:0]   seen_q,    seen_d;
    logic                    frame_q,   frame_d;
    logic                    err_q,     err_d;
    logic [2:0]              err_digit_q, err_digit_d;

    // Count low anodes and remember which one is low, for the one-hot check.
    always_comb begin
        low_count = 4'd0;
        sel_idx   = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!bus.an[i]) begin
                low_count = low_count + 4'd1;
                sel_idx   = 3'(i);
            end
        end
        one_hot  = (low_count == 4'd1);
        sel_mask = ~bus.an;
    end

    seg7_to_hex u_decode (
        .seg   (bus.seg),
        .hex   (dec_hex),
        .legal (dec_legal),
        .blank (dec_blank)
    );

    // Stability tracking, capture, frame bookkeeping and sticky error logic.
    always_comb begin
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        hex_d       = hex_q;
        valid_d     = valid_q;
        seen_d      = seen_q;
        frame_d     = 1'b0;
        err_d       = err_q;
        err_digit_d = err_digit_q;
        seen_next   = seen_q;
        capture     = 1'b0;
        illegal     = 1'b0;

        if (!one_hot) begin
            cnt_d  = 8'd0;
            done_d = 1'b0;
        end else if ({bus.an, bus.seg} == prev_q) begin
            if (cnt_q < STABLE_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d  = 8'd1;
            done_d = 1'b0;
            prev_d = {bus.an, bus.seg};
        end

        capture = one_hot && (cnt_d == STABLE_MAX) && !done_d;
        illegal = capture && !dec_legal && !dec_blank;

        if (capture) begin
            done_d = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_mask[i]) begin
                    hex_d[4*i +: 4] = dec_legal ? dec_hex : 4'h0;
                    valid_d[i]      = dec_legal;
                end
            end
            seen_next = seen_q | sel_mask;
            if (&seen_next) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d  = seen_next;
            end
        end

        if (illegal) begin
            err_d = 1'b1;
            if (!err_q || bus.err_clr) begin
                err_digit_d = sel_idx;
            end
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q      <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            hex_q       <= '0;
            valid_q     <= '0;
            seen_q      <= '0;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= '0;
        end else begin
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            hex_q       <= hex_d;
            valid_q     <= valid_d;
            seen_q      <= seen_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign bus.hex_value   = hex_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_valid = frame_q;
    assign bus.pattern_err = err_q;
    assign bus.err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Bench for seg7_frame_decoder: directed display scenarios followed by
// randomized dwells, all outputs compared every cycle against a dwell-level
// reference model.
module tb_seg7_frame_decoder;

    localparam int ND = 8;
    localparam int SC = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BAD   = 7'b1010101;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int num_vectors     = 0;
    int num_miscompares = 0;

    // Reference model state: dwell run length and the displayed picture.
    int         run_len;
    logic [7:0] last_an;
    logic [6:0] last_seg;
    logic [3:0] m_hex [ND];
    logic [7:0] m_valid;
    logic [7:0] m_seen;
    logic       m_frame;
    logic       m_err;
    logic [2:0] m_err_digit;

    seg7_frame_decoder_if #(.NUM_DIGITS(ND)) bus ();

    seg7_frame_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_vectors++;
        if (got !== exp) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        run_len     = 0;
        last_an     = '0;
        last_seg    = '0;
        for (int i = 0; i < ND; i++) m_hex[i] = 4'h0;
        m_valid     = '0;
        m_seen      = '0;
        m_frame     = 1'b0;
        m_err       = 1'b0;
        m_err_digit = '0;
    endtask

    // One clock of the display as the decoder should interpret it.
    task automatic modelStep(input logic [7:0] a, input logic [6:0] s, input logic ec, input logic rn);
        int  lows;
        int  d;
        int  g;
        logic bad;
        if (!rn) begin
            modelReset();
            return;
        end
        m_frame = 1'b0;
        bad     = 1'b0;
        lows    = 0;
        d       = 0;
        for (int i = 0; i < ND; i++) begin
            if (!a[i]) begin
                lows++;
                d = i;
            end
        end
        if (lows != 1) begin
            run_len = 0;
        end else begin
            if (run_len > 0 && a == last_an && s == last_seg) run_len++;
            else run_len = 1;
            last_an  = a;
            last_seg = s;
            if (run_len == SC) begin
                g = -1;
                for (int k = 0; k < 16; k++) if (GLYPH[k] == s) g = k;
                if (g >= 0) begin
                    m_hex[d]   = 4'(g);
                    m_valid[d] = 1'b1;
                end else begin
                    m_hex[d]   = 4'h0;
                    m_valid[d] = 1'b0;
                    bad        = (s != BLANK);
                end
                m_seen[d] = 1'b1;
                if (m_seen == 8'hFF) begin
                    m_frame = 1'b1;
                    m_seen  = '0;
                end
            end
        end
        if (bad) begin
            if (!m_err || ec) m_err_digit = 3'(d);
            m_err = 1'b1;
        end else if (ec) begin
            m_err = 1'b0;
        end
    endtask

    // Drive one cycle, advance the model on the edge, then compare all outputs.
    task automatic applyStimulus(input logic [7:0] a, input logic [6:0] s, input logic ec, input logic rn);
        logic [31:0] exp_hex;
        bus.an      = a;
        bus.seg     = s;
        bus.err_clr = ec;
        reset_n     = rn;
        @(posedge clk);
        modelStep(a, s, ec, rn);
        #1;
        for (int i = 0; i < ND; i++) exp_hex[4*i +: 4] = m_hex[i];
        checkOutput("hex_value",   bus.hex_value,          exp_hex);
        checkOutput("digit_valid", 32'(bus.digit_valid),   32'(m_valid));
        checkOutput("frame_valid", 32'(bus.frame_valid),   32'(m_frame));
        checkOutput("pattern_err", 32'(bus.pattern_err),   32'(m_err));
        checkOutput("err_digit",   32'(bus.err_digit),     32'(m_err_digit));
    endtask

    task automatic showDigit(input int d, input logic [6:0] s, input int n, input logic clr_last);
        logic [7:0] a;
        a    = 8'hFF;
        a[d] = 1'b0;
        for (int c = 0; c < n; c++) begin
            applyStimulus(a, s, (c == n - 1) ? clr_last : 1'b0, 1'b1);
        end
    endtask

    task automatic idle(input int n, input logic ec);
        for (int c = 0; c < n; c++) applyStimulus(8'hFF, BLANK, ec, 1'b1);
    endtask

    // Directed scenarios first, then randomized dwells.
    initial begin
        logic [7:0] a;
        logic [6:0] s;
        int         len;
        int         pick;

        modelReset();
        bus.an      = 8'hFF;
        bus.seg     = BLANK;
        bus.err_clr = 1'b0;

        applyStimulus(8'hFF, BLANK, 1'b0, 1'b0);
        applyStimulus(8'hFF, BLANK, 1'b0, 1'b0);
        checkOutput("reset_hex",   bus.hex_value,          32'h0);
        checkOutput("reset_valid", 32'(bus.digit_valid),   32'h0);
        checkOutput("reset_err",   32'(bus.pattern_err),   32'h0);

        // Full legal frame showing 1..8 on digits 0..7.
        for (int d = 0; d < ND; d++) begin
            showDigit(d, GLYPH[d + 1], SC, 1'b0);
            if (d < ND - 1) checkOutput("frame_early", 32'(bus.frame_valid), 32'h0);
        end
        checkOutput("frame_pulse", 32'(bus.frame_valid), 32'h1);
        checkOutput("frame_hex",   bus.hex_value,        32'h87654321);
        checkOutput("frame_valid_mask", 32'(bus.digit_valid), 32'hFF);
        idle(1, 1'b0);
        checkOutput("frame_one_cycle", 32'(bus.frame_valid), 32'h0);

        // Short dwell leaves digit 3 alone.
        showDigit(3, GLYPH[10], SC - 1, 1'b0);
        idle(2, 1'b0);
        checkOutput("short_nibble", 32'(bus.hex_value[15:12]), 32'h4);
        checkOutput("short_valid",  32'(bus.digit_valid[3]),   32'h1);

        // Blank is not an error; an unknown pattern is.
        showDigit(2, BLANK, SC, 1'b0);
        checkOutput("blank_valid", 32'(bus.digit_valid[2]), 32'h0);
        checkOutput("blank_err",   32'(bus.pattern_err),    32'h0);
        idle(1, 1'b0);
        showDigit(5, BAD, SC, 1'b0);
        checkOutput("bad_err",    32'(bus.pattern_err),       32'h1);
        checkOutput("bad_digit",  32'(bus.err_digit),         32'h5);
        checkOutput("bad_nibble", 32'(bus.hex_value[23:20]),  32'h0);

        // Clear racing an illegal capture: the error wins and reloads.
        showDigit(6, BAD, SC, 1'b1);
        checkOutput("race_err",   32'(bus.pattern_err), 32'h1);
        checkOutput("race_digit", 32'(bus.err_digit),   32'h6);
        idle(1, 1'b1);
        checkOutput("clr_err",   32'(bus.pattern_err), 32'h0);
        checkOutput("clr_digit", 32'(bus.err_digit),   32'h6);

        // Two anodes low: never qualifies.
        for (int c = 0; c < 10; c++) applyStimulus(8'b11110011, GLYPH[9], 1'b0, 1'b1);

        // Reset in the middle of a dwell restarts the stability count.
        showDigit(0, GLYPH[15], 2, 1'b0);
        applyStimulus(8'hFE, GLYPH[15], 1'b0, 1'b0);
        showDigit(0, GLYPH[15], SC - 1, 1'b0);
        checkOutput("rst_pre_nibble", 32'(bus.hex_value[3:0]), 32'h0);
        checkOutput("rst_pre_valid",  32'(bus.digit_valid[0]), 32'h0);
        showDigit(0, GLYPH[15], 1, 1'b0);
        checkOutput("rst_cap_nibble", 32'(bus.hex_value[3:0]), 32'hF);
        checkOutput("rst_cap_valid",  32'(bus.digit_valid[0]), 32'h1);

        // Randomized dwells with glitches, gaps, stray anodes and clears.
        for (int n = 0; n < 400; n++) begin
            a    = 8'hFF;
            a[$urandom_range(0, ND - 1)] = 1'b0;
            pick = $urandom_range(0, 9);
            if (pick <= 6)      s = GLYPH[$urandom_range(0, 15)];
            else if (pick == 7) s = BLANK;
            else                s = 7'($urandom);
            len = $urandom_range(1, 7);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 9) == 0)
                    applyStimulus(a, s ^ (7'd1 << $urandom_range(0, 6)), $urandom_range(0, 15) == 0, 1'b1);
                else
                    applyStimulus(a, s, $urandom_range(0, 15) == 0, 1'b1);
            end
            case ($urandom_range(0, 5))
                0: idle(1, $urandom_range(0, 7) == 0);
                1: applyStimulus(8'($urandom), 7'($urandom), 1'b0, 1'b1);
                2: if ($urandom_range(0, 19) == 0) applyStimulus(a, s, 1'b0, 1'b0);
                default: ;
            endcase
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule
